// File: rtl/corevx_ptw_mc_if.sv
// Port bundle for corevx_ptw_mc: TLB miss/resolve channels plus the Avalon-MM read master.
// "master" is the walker's view, "slave" is the TLBs' and memory's view.
interface corevx_ptw_mc_if #(
  parameter int CHANNELS = 2
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]    resolve_request;
  logic [CHANNELS*20-1:0] resolve_virtual_address;
  logic [CHANNELS-1:0]    resolve_ack;
  logic [CHANNELS-1:0]    resolve_done;
  logic [CW-1:0]          resolve_channel;
  logic                   resolve_pagefault;
  logic                   resolve_accessfault;
  logic [7:0]             resolve_access_bits;
  logic [21:0]            resolve_physical_address;

  logic [33:0]            avl_address;
  logic                   avl_read;
  logic                   avl_waitrequest;
  logic                   avl_readdatavalid;
  logic [31:0]            avl_readdata;
  logic [1:0]             avl_response;

  modport master (
    input  resolve_request, resolve_virtual_address,
    output resolve_ack, resolve_done, resolve_channel, resolve_pagefault,
    output resolve_accessfault, resolve_access_bits, resolve_physical_address,
    output avl_address, avl_read,
    input  avl_waitrequest, avl_readdatavalid, avl_readdata, avl_response
  );

  modport slave (
    output resolve_request, resolve_virtual_address,
    input  resolve_ack, resolve_done, resolve_channel, resolve_pagefault,
    input  resolve_accessfault, resolve_access_bits, resolve_physical_address,
    input  avl_address, avl_read,
    output avl_waitrequest, avl_readdatavalid, avl_readdata, avl_response
  );
endinterface

// File: rtl/corevx_ptw_mc.sv
// Multi-channel Sv32 page-table walker with round-robin arbitration over TLB miss ports.
// Define COREVX_PTW_AD_CHECK_EN to fault on valid leaves whose A bit is clear.
module corevx_ptw_mc #(
  parameter int CHANNELS = 2,
  parameter int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  matp_mode,
  input  logic [21:0]           matp_ppn,
  corevx_ptw_mc_if.master       bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  state_t               state_r;
  logic [CW-1:0]        rr_ptr_r;
  logic [9:0]           vpn_lo_r;
  logic                 level_r;

  logic                 gnt_valid_s;
  logic [CW-1:0]        gnt_idx_s;
  logic [CW-1:0]        cand_s;
  logic [31:0]          pos_s;
  logic [CW-1:0]        nxt_ptr_s;
  logic [CHANNELS-1:0]  gnt_oh_s;
  logic [CHANNELS-1:0]  chan_oh_s;
  logic [19:0]          vpn_sel_s;
  logic                 grant_s;
  logic                 leaf_s;
  logic                 af_s;
  logic                 pf_s;
  logic                 walk_next_s;
  logic [21:0]          leaf_ppn_s;
  logic                 unused_rsw_s;

  // Round-robin pick: first requesting channel at or after rr_ptr_r, wrapping.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_idx_s   = '0;
    cand_s      = '0;
    pos_s       = 32'd0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      pos_s = 32'(rr_ptr_r) + 32'(k);
      pos_s = (pos_s >= 32'(CHANNELS)) ? (pos_s - 32'(CHANNELS)) : pos_s;
      cand_s = pos_s[CW-1:0];
      gnt_valid_s = gnt_valid_s | bus.resolve_request[cand_s];
      gnt_idx_s   = bus.resolve_request[cand_s] ? cand_s : gnt_idx_s;
    end
    nxt_ptr_s = (gnt_idx_s == CW'(CHANNELS - 1)) ? '0 : (gnt_idx_s + CW'(1));
  end

  // One-hot views of the winner and of the owning channel, plus the winner's VPN.
  always_comb begin
    gnt_oh_s  = '0;
    chan_oh_s = '0;
    vpn_sel_s = 20'h00000;
    for (int i = 0; i < CHANNELS; i++) begin
      gnt_oh_s[i]  = (gnt_idx_s == CW'(i));
      chan_oh_s[i] = (bus.resolve_channel == CW'(i));
      vpn_sel_s    = vpn_sel_s | (gnt_oh_s[i] ? bus.resolve_virtual_address[20*i +: 20] : 20'h00000);
    end
  end

  // PTE classification; the priority order decides which fault wins.
  always_comb begin
    leaf_s       = bus.avl_readdata[1] | bus.avl_readdata[3];
    af_s         = (bus.avl_response != 2'b00);
    pf_s         = 1'b0;
    walk_next_s  = 1'b0;
    unused_rsw_s = ^bus.avl_readdata[9:8];
    if (af_s) begin
      pf_s = 1'b0;
    end else if (!bus.avl_readdata[0] || (!bus.avl_readdata[1] && bus.avl_readdata[2])) begin
      pf_s = 1'b1;
    end else if (leaf_s) begin
      if (level_r && (bus.avl_readdata[19:10] != 10'h000)) begin
        pf_s = 1'b1;
`ifdef COREVX_PTW_AD_CHECK_EN
      end else if (!bus.avl_readdata[6]) begin
        pf_s = 1'b1;
`endif
      end else begin
        pf_s = 1'b0;
      end
    end else if (level_r) begin
      walk_next_s = 1'b1;
    end else begin
      pf_s = 1'b1;
    end
    leaf_ppn_s = level_r ? {bus.avl_readdata[31:20], vpn_lo_r} : bus.avl_readdata[31:10];
  end

  // RESULT may grant directly once done has pulsed, so a new walk can be acked right after done.
  assign grant_s = gnt_valid_s &&
                   ((state_r == ST_IDLE) || ((state_r == ST_RESULT) && (bus.resolve_done != '0)));

  // Walk FSM and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r                      <= ST_IDLE;
      rr_ptr_r                     <= '0;
      vpn_lo_r                     <= 10'h000;
      level_r                      <= 1'b0;
      bus.resolve_ack              <= '0;
      bus.resolve_done             <= '0;
      bus.resolve_channel          <= '0;
      bus.resolve_pagefault        <= 1'b0;
      bus.resolve_accessfault      <= 1'b0;
      bus.resolve_access_bits      <= 8'h00;
      bus.resolve_physical_address <= 22'h000000;
      bus.avl_read                 <= 1'b0;
      bus.avl_address              <= 34'h0_0000_0000;
    end else begin
      bus.resolve_ack <= '0;
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        ST_ISSUE: begin
          if (!bus.avl_waitrequest) begin
            bus.avl_read <= 1'b0;
            state_r      <= ST_WAIT;
          end else begin
            state_r      <= ST_ISSUE;
          end
        end
        ST_WAIT: begin
          if (!bus.avl_readdatavalid) begin
            state_r <= ST_WAIT;
          end else if (walk_next_s) begin
            level_r         <= 1'b0;
            bus.avl_read    <= 1'b1;
            bus.avl_address <= {bus.avl_readdata[31:10], vpn_lo_r, 2'b00};
            state_r         <= ST_ISSUE;
          end else begin
            bus.resolve_done             <= chan_oh_s;
            bus.resolve_pagefault        <= pf_s;
            bus.resolve_accessfault      <= af_s;
            bus.resolve_access_bits      <= bus.avl_readdata[7:0];
            bus.resolve_physical_address <= leaf_ppn_s;
            state_r                      <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          // Bare-mode walks arrive here without done set and pulse it one cycle later.
          if (bus.resolve_done == '0) begin
            bus.resolve_done <= chan_oh_s;
            state_r          <= ST_RESULT;
          end else begin
            bus.resolve_done <= '0;
            state_r          <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      if (grant_s) begin
        bus.resolve_ack     <= gnt_oh_s;
        bus.resolve_channel <= gnt_idx_s;
        rr_ptr_r            <= nxt_ptr_s;
        vpn_lo_r            <= vpn_sel_s[9:0];
        if (!matp_mode) begin
          bus.resolve_physical_address <= {2'b00, vpn_sel_s};
          bus.resolve_access_bits      <= 8'hCF;
          bus.resolve_pagefault        <= 1'b0;
          bus.resolve_accessfault      <= 1'b0;
          state_r                      <= ST_RESULT;
        end else begin
          level_r         <= 1'b1;
          bus.avl_read    <= 1'b1;
          bus.avl_address <= {matp_ppn, vpn_sel_s[19:10], 2'b00};
          state_r         <= ST_ISSUE;
        end
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

endmodule

// File: tb/tb_corevx_ptw_mc.sv
// Scoreboard bench for corevx_ptw_mc: directed walks, expected results queued at ack time,
// a negedge monitor pops and compares on every resolve_done.
module tb_corevx_ptw_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        matp_mode = 1'b1;
  logic [21:0] matp_ppn = 22'h000000;

  corevx_ptw_mc_if #(.CHANNELS(2)) bus ();

  corevx_ptw_mc #(.CHANNELS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .matp_mode (matp_mode),
    .matp_ppn  (matp_ppn),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic        pf;
    logic        af;
    logic [21:0] ppn;
    logic [7:0]  bits;
    int          start;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          grant_log[$];
  logic [33:0] rd_addr_q[$];
  logic [31:0] mem [int];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          n_reads = 0;
  int          err_word = 1024;
  bit          rand_wait = 1'b0;
  int          extra_lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Avalon memory model: one outstanding read, latency 1 + extra_lat, optional random stalls.
  initial begin
    bit          pend;
    int          cnt;
    bit          prev_stall;
    bit          wr;
    logic [33:0] prev_addr;
    logic [33:0] acc_addr;
    int          w;
    pend = 1'b0; cnt = 0; prev_stall = 1'b0; prev_addr = '0; acc_addr = '0;
    bus.avl_waitrequest   = 1'b0;
    bus.avl_readdatavalid = 1'b0;
    bus.avl_readdata      = 32'h0;
    bus.avl_response      = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0; prev_stall = 1'b0;
        bus.avl_readdatavalid = 1'b0;
        bus.avl_waitrequest   = 1'b0;
        continue;
      end
      if (pend && cnt == 0) begin
        w = int'(acc_addr[33:2]);
        bus.avl_readdatavalid = 1'b1;
        bus.avl_readdata      = mem.exists(w) ? mem[w] : 32'h0;
        bus.avl_response      = (w == err_word) ? 2'b10 : 2'b00;
        pend = 1'b0;
      end else begin
        bus.avl_readdatavalid = 1'b0;
        if (pend) cnt--;
      end
      if (prev_stall) begin
        chk("addr_stable", bus.avl_address, prev_addr);
        chk("read_held", bus.avl_read, 1);
      end
      wr = rand_wait ? ($urandom_range(0, 1) == 1) : 1'b0;
      bus.avl_waitrequest = wr;
      prev_stall = bus.avl_read && wr;
      prev_addr  = bus.avl_address;
      if (bus.avl_read && !wr) begin
        pend = 1'b1; cnt = extra_lat; acc_addr = bus.avl_address;
        rd_addr_q.push_back(bus.avl_address);
        n_reads++;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.resolve_done != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", bus.resolve_done, 0);
        end else begin
          e = exp_q.pop_front();
          chk("done_onehot", bus.resolve_done, 1 << e.ch);
          chk("resolve_channel", bus.resolve_channel, e.ch);
          chk("pagefault", bus.resolve_pagefault, e.pf);
          chk("accessfault", bus.resolve_accessfault, e.af);
          chk("fault_exclusive", bus.resolve_pagefault & bus.resolve_accessfault, 0);
          if (!e.pf && !e.af) begin
            chk("ppn", bus.resolve_physical_address, e.ppn);
            chk("access_bits", bus.resolve_access_bits, e.bits);
          end
          if (e.lat >= 0) chk("done_cycle", cyc - e.start, e.lat);
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("done_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic walk(input int ch, input logic [19:0] vpn, input logic pf, input logic af,
                      input logic [21:0] ppn, input logic [7:0] bits,
                      input int ack_lat, input int done_lat);
    int   start;
    bit   got;
    exp_t e;
    @(negedge clk);
    bus.resolve_virtual_address[ch*20 +: 20] = vpn;
    bus.resolve_request[ch] = 1'b1;
    start = cyc;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.resolve_ack != 2'b00) begin
        got = 1'b1;
        chk("ack_onehot", bus.resolve_ack, 1 << ch);
        if (ack_lat >= 0) chk("ack_cycle", cyc - start, ack_lat);
        e.ch = ch; e.pf = pf; e.af = af; e.ppn = ppn; e.bits = bits;
        e.start = start; e.lat = done_lat;
        exp_q.push_back(e);
        bus.resolve_request[ch] = 1'b0;
      end
    end
    if (!got) begin
      chk("ack_timeout", 0, 1);
      bus.resolve_request[ch] = 1'b0;
    end
    drain();
  endtask

  task automatic drive_ch(input int ch, input logic [19:0] vpn, input logic [21:0] ppn, input int n);
    int   got;
    exp_t e;
    got = 0;
    @(negedge clk);
    bus.resolve_virtual_address[ch*20 +: 20] = vpn;
    bus.resolve_request[ch] = 1'b1;
    for (int i = 0; i < 400 && got < n; i++) begin
      @(negedge clk);
      if (bus.resolve_ack[ch]) begin
        got++;
        grant_log.push_back(ch);
        e.ch = ch; e.pf = 1'b0; e.af = 1'b0; e.ppn = ppn; e.bits = 8'hCF;
        e.start = cyc; e.lat = -1;
        exp_q.push_back(e);
        if (got == n) bus.resolve_request[ch] = 1'b0;
      end
    end
    if (got != n) begin
      chk("grant_timeout", got, n);
      bus.resolve_request[ch] = 1'b0;
    end
  endtask

  initial begin
    int  r0;
    bit  seen;
    logic ad_pf;
    bus.resolve_request = 2'b00;
    bus.resolve_virtual_address = 40'h0;
    mem[2]    = 32'h0000_0401;
    mem[3]    = 32'h0010_00CF;
    mem[4]    = 32'h0020_00CF;
    mem[5]    = 32'h0000_0801;
    mem[6]    = 32'h0030_008B;
    mem[13]   = 32'h0000_04CF;
    mem[2048] = 32'h0000_00CE;
    mem[2049] = 32'h0000_00C5;
    mem[2050] = 32'h0000_00CD;
    mem[2051] = 32'h0048_D0CB;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", bus.resolve_ack, 0);
    chk("rst_done", bus.resolve_done, 0);
    chk("rst_channel", bus.resolve_channel, 0);
    chk("rst_faults", {bus.resolve_pagefault, bus.resolve_accessfault}, 0);
    chk("rst_bits", bus.resolve_access_bits, 0);
    chk("rst_ppn", bus.resolve_physical_address, 0);
    chk("rst_avl_read", bus.avl_read, 0);
    chk("rst_avl_addr", bus.avl_address, 0);

    // Both channels requesting continuously: grants must alternate starting at 0.
    grant_log.delete();
    fork
      drive_ch(0, 20'h00C00, 22'h000400, 3);
      drive_ch(1, 20'h01005, 22'h000805, 3);
    join
    drain();
    chk("rr_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) chk("rr_order", grant_log[i], i % 2);

    // Megapage, zero wait.
    walk(0, 20'h00C00, 1'b0, 1'b0, 22'h000400, 8'hCF, 1, 3);

    // Level-0 read hits the PMA error word.
    rd_addr_q.delete();
    walk(1, 20'h00800, 1'b0, 1'b1, 22'h0, 8'h0, 1, 5);
    chk("l0_reads", rd_addr_q.size(), 2);
    if (rd_addr_q.size() == 2) begin
      chk("l1_addr", rd_addr_q[0], 34'h8);
      chk("l0_addr", rd_addr_q[1], 34'h1000);
    end

    // Page faults: misaligned megapage, then V=0, W-only and XW leaves at level 0.
    walk(0, 20'h03400, 1'b1, 1'b0, 22'h0, 8'h0, 1, 3);
    walk(1, 20'h01400, 1'b1, 1'b0, 22'h0, 8'h0, 1, 5);
    walk(0, 20'h01401, 1'b1, 1'b0, 22'h0, 8'h0, 1, 5);
    walk(1, 20'h01402, 1'b1, 1'b0, 22'h0, 8'h0, 1, 5);
    walk(0, 20'h01403, 1'b0, 1'b0, 22'h001234, 8'hCB, 1, 5);

    // Bare mode: no memory traffic.
    matp_mode = 1'b0;
    r0 = n_reads;
    walk(1, 20'hABCDE, 1'b0, 1'b0, 22'h0ABCDE, 8'hCF, 1, 2);
    chk("bare_no_read", n_reads - r0, 0);
    matp_mode = 1'b1;

    // Leaf with A = 0.
`ifdef COREVX_PTW_AD_CHECK_EN
    ad_pf = 1'b1;
`else
    ad_pf = 1'b0;
`endif
    walk(0, 20'h01800, ad_pf, 1'b0, 22'h000C00, 8'h8B, 1, 3);

    // Random stalls.
    rand_wait = 1'b1;
    walk(1, 20'h01005, 1'b0, 1'b0, 22'h000805, 8'hCF, 1, -1);
    walk(0, 20'h01403, 1'b0, 1'b0, 22'h001234, 8'hCB, 1, -1);

    // Reset while waiting for PTE data; rr pointer is at 1 before reset.
    walk(1, 20'h01403, 1'b0, 1'b0, 22'h001234, 8'hCB, 1, -1);
    extra_lat = 3;
    @(negedge clk);
    bus.resolve_virtual_address[19:0] = 20'h00C00;
    bus.resolve_request[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.resolve_ack[0]) begin
        seen = 1'b1;
        bus.resolve_request[0] = 1'b0;
      end
    end
    chk("rstw_ack_seen", seen, 1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (!bus.avl_read) seen = 1'b1;
    end
    chk("rstw_in_wait", seen, 1);
    rst = 1'b1;
    #1;
    chk("rstw_avl_read", bus.avl_read, 0);
    chk("rstw_avl_addr", bus.avl_address, 0);
    chk("rstw_ppn", bus.resolve_physical_address, 0);
    chk("rstw_bits", bus.resolve_access_bits, 0);
    chk("rstw_flags", {bus.resolve_ack, bus.resolve_done, bus.resolve_channel,
                       bus.resolve_pagefault, bus.resolve_accessfault}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    extra_lat = 0;
    repeat (3) @(negedge clk);
    grant_log.delete();
    fork
      drive_ch(0, 20'h00C00, 22'h000400, 1);
      drive_ch(1, 20'h01005, 22'h000805, 1);
    join
    drain();
    chk("post_rst_count", grant_log.size(), 2);
    if (grant_log.size() > 0) chk("post_rst_first", grant_log[0], 0);
    rand_wait = 1'b0;

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
